// File: rtl/cu_mc_pkg.sv
// cu_mc_pkg: shared encodings for the multicycle RV32I control unit.
package cu_mc_pkg;
  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_U, S_WB_ALU, S_BR, S_JAL,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_TRAP
  } state_t;
  typedef enum logic [1:0] {CL_ADD, CL_R, CL_I, CL_BR} alu_cls_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [1:0] SA_RS1 = 2'b00, SA_PC = 2'b01, SA_ZERO = 2'b10, SA_OLDPC = 2'b11;
  localparam logic [2:0] SB_RS2 = 3'b000, SB_4 = 3'b001, SB_IIMM = 3'b010, SB_SIMM = 3'b011, SB_UIMM = 3'b110;
  localparam logic [1:0] PC_ALU = 2'b00, PC_BR = 2'b01, PC_JAL = 2'b10, PC_JALR = 2'b11;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MEM = 2'b01, M2R_PC4 = 2'b10;
  localparam logic [1:0] TC_NONE = 2'b00, TC_ILL = 2'b01, TC_IMEM = 2'b10, TC_DMEM = 2'b11;
endpackage

// File: rtl/cu_alu_dec.sv
// cu_alu_dec: maps instruction class, funct3 and funct7[5] to the ALU operation.
module cu_alu_dec
  import cu_mc_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output logic [3:0] alu_op
);
  logic [3:0] base;
  always_comb begin
    case (funct3)
      3'b000:  base = (cls == CL_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  base = ALU_SLL;
      3'b010:  base = ALU_SLT;
      3'b011:  base = ALU_SLTU;
      3'b100:  base = ALU_XOR;
      3'b101:  base = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  base = ALU_OR;
      default: base = ALU_AND;
    endcase
    alu_op = cls == CL_ADD ? ALU_ADD :
             cls == CL_BR  ? (funct3[2:1] == 2'b10 ? ALU_SLT : funct3[2:1] == 2'b11 ? ALU_SLTU : ALU_SUB) :
             base;
  end
endmodule

// File: rtl/cu_mc_hs.sv
// cu_mc_hs: multicycle RV32I control unit with ready/valid memory handshakes, timeout and trap.
// Define CU_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module cu_mc_hs
  import cu_mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             cu_IRwrite,
  output logic             cu_Regwrite,
  output logic             cu_PCwrite,
  output logic             cu_Branch,
  output logic [1:0]       cu_Mem2Reg,
  output logic [1:0]       cu_PCsrc,
  output logic [1:0]       cu_ALUsrcA,
  output logic [2:0]       cu_ALUsrcB,
  output logic [3:0]       alu_op,
  output logic             cu_BrLt,
  output logic             cu_BrInv,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       dmem_size,
  output logic [4:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  state_t          st, nxt;
  alu_cls_t        cls;
  logic [3:0]      dec_op;
  logic [1:0]      ncause;
  logic [TO_W-1:0] wcnt;
  logic            to_hit, waiting, retire, unused_f7;
  assign state     = st;
  assign unused_f7 = ^{funct7[6], funct7[4:0]};
  // the timeout fires on the last allowed wait cycle unless ready arrives in it
  assign to_hit    = (MEM_TIMEOUT != 0) && (wcnt == TO_LAST);
  assign waiting   = st inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign retire    = nxt == S_FETCH && st inside {S_WB_ALU, S_BR, S_JAL, S_MEM_WR, S_WB_MEM};
  always_comb
    cls = st == S_EX_R ? CL_R :
          (st == S_EX_I && opcode != OP_JALR) ? CL_I :
          st == S_BR ? CL_BR : CL_ADD;
  cu_alu_dec u_alu_dec (.cls(cls), .funct3(funct3), .f7b5(funct7[5]), .alu_op(dec_op));
  always_comb begin
    nxt = st;
    ncause = TC_NONE;
    cu_IRwrite = 1'b0;
    cu_Regwrite = 1'b0;
    cu_PCwrite = 1'b0;
    cu_Branch = 1'b0;
    cu_Mem2Reg = M2R_ALU;
    cu_PCsrc = PC_ALU;
    cu_ALUsrcA = SA_RS1;
    cu_ALUsrcB = SB_RS2;
    alu_op = 4'b0000;
    cu_BrLt = 1'b0;
    cu_BrInv = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    dmem_size = 3'b000;
    if (rst_n)
      case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          cu_ALUsrcA = SA_PC;
          cu_ALUsrcB = SB_4;
          alu_op = dec_op;
          if (imem_ready) begin
            cu_IRwrite = 1'b1;
            cu_PCwrite = 1'b1;
            nxt = S_DECODE;
          end else if (to_hit) begin
            nxt = S_TRAP;
            ncause = TC_IMEM;
          end
        end
        S_DECODE:
          case (opcode)
            OP_R:                nxt = S_EX_R;
            OP_IMM, OP_JALR:     nxt = S_EX_I;
            OP_BRANCH:           nxt = S_BR;
            OP_JAL:              nxt = S_JAL;
            OP_LOAD, OP_STORE:   nxt = S_MEM_ADDR;
            OP_LUI, OP_AUIPC:    nxt = S_EX_U;
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
              nxt = S_TRAP;
              ncause = TC_ILL;
`else
              nxt = S_FETCH;
`endif
            end
          endcase
        S_EX_R: begin
          alu_op = dec_op;
          nxt = S_WB_ALU;
        end
        S_EX_I: begin
          cu_ALUsrcB = SB_IIMM;
          alu_op = dec_op;
          nxt = S_WB_ALU;
        end
        S_EX_U: begin
          cu_ALUsrcA = opcode == OP_AUIPC ? SA_OLDPC : SA_ZERO;
          cu_ALUsrcB = SB_UIMM;
          alu_op = dec_op;
          nxt = S_WB_ALU;
        end
        S_WB_ALU: begin
          cu_Regwrite = 1'b1;
          if (opcode == OP_JALR) begin
            cu_PCwrite = 1'b1;
            cu_PCsrc = PC_JALR;
            cu_Mem2Reg = M2R_PC4;
          end
          nxt = S_FETCH;
        end
        S_BR: begin
          cu_Branch = 1'b1;
          cu_PCsrc = PC_BR;
          alu_op = dec_op;
          cu_BrLt = funct3[2];
          cu_BrInv = funct3[0];
          nxt = S_FETCH;
        end
        S_JAL: begin
          cu_Regwrite = 1'b1;
          cu_Mem2Reg = M2R_PC4;
          cu_PCwrite = 1'b1;
          cu_PCsrc = PC_JAL;
          nxt = S_FETCH;
        end
        S_MEM_ADDR: begin
          cu_ALUsrcB = opcode == OP_STORE ? SB_SIMM : SB_IIMM;
          alu_op = dec_op;
          nxt = opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD, S_MEM_WR: begin
          dmem_req = 1'b1;
          dmem_we = st == S_MEM_WR;
          dmem_size = funct3;
          if (dmem_ready) nxt = st == S_MEM_RD ? S_WB_MEM : S_FETCH;
          else if (to_hit) begin
            nxt = S_TRAP;
            ncause = TC_DMEM;
          end
        end
        S_WB_MEM: begin
          cu_Regwrite = 1'b1;
          cu_Mem2Reg = M2R_MEM;
          nxt = S_FETCH;
        end
        S_TRAP: nxt = S_TRAP;
        default: nxt = S_FETCH;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_FETCH;
      wcnt <= '0;
      instret <= '0;
      trap <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      st <= nxt;
      wcnt <= (nxt == st && waiting) ? wcnt + TO_W'(1) : '0;
      if (retire) instret <= instret + CNT_W'(1);
      if (nxt == S_TRAP && st != S_TRAP) begin
        trap <= 1'b1;
        trap_cause <= ncause;
      end
    end
endmodule

// File: tb/tb_cu_mc_hs.sv
// tb_cu_mc_hs: scoreboard bench for cu_mc_hs built with CNT_W=4, MEM_TIMEOUT=5.
// Expectations for illegal opcodes follow CU_ILLEGAL_TRAP_EN.
module tb_cu_mc_hs;
  import cu_mc_pkg::*;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BRA = 7'b1100011, JL = 7'b1101111, JLR = 7'b1100111, LU = 7'b0110111, AUI = 7'b0010111;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic cu_IRwrite, cu_Regwrite, cu_PCwrite, cu_Branch, cu_BrLt, cu_BrInv;
  logic [1:0] cu_Mem2Reg, cu_PCsrc, cu_ALUsrcA, trap_cause;
  logic [2:0] cu_ALUsrcB, dmem_size;
  logic [3:0] alu_op, instret;
  logic imem_req, dmem_req, dmem_we, trap;
  logic [4:0] state;
  int checks = 0, errors = 0, exp_ret = 0;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic imr, dmr;
    logic [4:0] st; logic rw; logic [1:0] m2r; logic dreq, we; logic [2:0] sz; logic [3:0] alu; logic ca;
  } step_t;
  step_t tbl[$];
  step_t q[$];

  cu_mc_hs #(.CNT_W(4), .MEM_TIMEOUT(5), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .cu_IRwrite(cu_IRwrite),
    .cu_Regwrite(cu_Regwrite), .cu_PCwrite(cu_PCwrite), .cu_Branch(cu_Branch),
    .cu_Mem2Reg(cu_Mem2Reg), .cu_PCsrc(cu_PCsrc), .cu_ALUsrcA(cu_ALUsrcA),
    .cu_ALUsrcB(cu_ALUsrcB), .alu_op(alu_op), .cu_BrLt(cu_BrLt), .cu_BrInv(cu_BrInv),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .state(state), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  function automatic void row(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic imr, logic dmr,
                              logic [4:0] st, logic rw, logic [1:0] m2r, logic dreq, logic we,
                              logic [2:0] sz, logic [3:0] alu, logic ca);
    tbl.push_back('{op, f3, f7, imr, dmr, st, rw, m2r, dreq, we, sz, alu, ca});
  endfunction

  function automatic void instr4(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] exs, logic [3:0] alu);
    row(op, f3, f7, 1, 0, S_FETCH,  0, 0, 0, 0, 0, 4'b0010, 1);
    row(op, f3, f7, 1, 0, S_DECODE, 0, 0, 0, 0, 0, 0, 0);
    row(op, f3, f7, 1, 0, exs,      0, 0, 0, 0, 0, alu, 1);
    row(op, f3, f7, 1, 0, S_WB_ALU, 1, 2'b00, 0, 0, 0, 0, 0);
    exp_ret++;
  endfunction

  task automatic test_reset();
    imem_ready = 1'b1;
    opcode = OPR;
    #2;
    checks++;
    if (state !== S_FETCH || instret !== 4'd0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_regs: state=%0d instret=%0d trap=%b cause=%b, want 0/0/0/00", state, instret, trap, trap_cause);
    end
    checks++;
    if (imem_req !== 1'b0 || cu_IRwrite !== 1'b0 || cu_PCwrite !== 1'b0 || alu_op !== 4'd0 || cu_ALUsrcA !== 2'd0 || cu_ALUsrcB !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: imem_req=%b irw=%b pcw=%b alu=%b A=%b B=%b, want all 0", imem_req, cu_IRwrite, cu_PCwrite, alu_op, cu_ALUsrcA, cu_ALUsrcB);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_table(string name);
    step_t s, e;
    while (tbl.size() > 0) begin
      s = tbl.pop_front();
      opcode = s.op; funct3 = s.f3; funct7 = s.f7; imem_ready = s.imr; dmem_ready = s.dmr;
      q.push_back(s);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (state !== e.st) begin errors++; $display("FAIL %s state: got %0d want %0d", name, state, e.st); end
      checks++;
      if (cu_Regwrite !== e.rw) begin errors++; $display("FAIL %s regwrite in state %0d: got %b want %b", name, e.st, cu_Regwrite, e.rw); end
      checks++;
      if ({dmem_req, dmem_we, dmem_size} !== {e.dreq, e.we, e.sz}) begin
        errors++;
        $display("FAIL %s dmem in state %0d: got req=%b we=%b size=%b want %b/%b/%b", name, e.st, dmem_req, dmem_we, dmem_size, e.dreq, e.we, e.sz);
      end
      if (e.rw) begin
        checks++;
        if (cu_Mem2Reg !== e.m2r) begin errors++; $display("FAIL %s mem2reg: got %b want %b", name, cu_Mem2Reg, e.m2r); end
      end
      if (e.ca) begin
        checks++;
        if (alu_op !== e.alu) begin errors++; $display("FAIL %s alu_op in state %0d: got %b want %b", name, e.st, alu_op, e.alu); end
      end
      tick();
    end
    checks++;
    if (instret !== 4'(exp_ret)) begin errors++; $display("FAIL %s instret: got %0d want %0d", name, instret, 4'(exp_ret)); end
  endtask

  task automatic test_alu_ops();
    instr4(OPR, 3'b000, 7'h00, S_EX_R, 4'b0010);
    instr4(OPR, 3'b000, 7'h20, S_EX_R, 4'b0110);
    instr4(OPR, 3'b101, 7'h20, S_EX_R, 4'b1001);
    instr4(OPR, 3'b101, 7'h00, S_EX_R, 4'b1000);
    instr4(OPR, 3'b011, 7'h00, S_EX_R, 4'b0011);
    instr4(OPR, 3'b001, 7'h00, S_EX_R, 4'b0100);
    instr4(OPR, 3'b110, 7'h00, S_EX_R, 4'b0001);
    instr4(OPI, 3'b101, 7'h20, S_EX_I, 4'b1001);
    instr4(OPI, 3'b000, 7'h20, S_EX_I, 4'b0010);
    instr4(OPI, 3'b100, 7'h00, S_EX_I, 4'b0101);
    instr4(OPI, 3'b111, 7'h00, S_EX_I, 4'b0000);
    run_table("alu_ops");
  endtask

  task automatic test_load_store();
    row(LD, 3'b010, 0, 1, 0, S_FETCH,    0, 0, 0, 0, 0, 4'b0010, 1);
    row(LD, 3'b010, 0, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 0, 0);
    row(LD, 3'b010, 0, 1, 0, S_MEM_ADDR, 0, 0, 0, 0, 0, 4'b0010, 1);
    for (int i = 0; i < 4; i++)
      row(LD, 3'b010, 0, 0, i == 3, S_MEM_RD, 0, 0, 1, 0, 3'b010, 0, 0);
    row(LD, 3'b010, 0, 0, 0, S_WB_MEM,   1, 2'b01, 0, 0, 0, 0, 0);
    row(SW, 3'b001, 0, 1, 0, S_FETCH,    0, 0, 0, 0, 0, 4'b0010, 1);
    row(SW, 3'b001, 0, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 0, 0);
    row(SW, 3'b001, 0, 1, 0, S_MEM_ADDR, 0, 0, 0, 0, 0, 4'b0010, 1);
    row(SW, 3'b001, 0, 1, 0, S_MEM_WR,   0, 0, 1, 1, 3'b001, 0, 0);
    row(SW, 3'b001, 0, 1, 1, S_MEM_WR,   0, 0, 1, 1, 3'b001, 0, 0);
    exp_ret += 2;
    run_table("load_store");
  endtask

  task automatic test_branch_jump();
    logic [2:0] bf3[3] = '{3'b111, 3'b000, 3'b100};
    logic [3:0] balu[3] = '{4'b0011, 4'b0110, 4'b0111};
    logic blt[3] = '{1'b1, 1'b0, 1'b1};
    logic binv[3] = '{1'b1, 1'b0, 1'b0};
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = BRA; funct3 = bf3[i];
      @(negedge clk);
      checks++;
      if (imem_req !== 1 || cu_IRwrite !== 1 || cu_PCwrite !== 1 || cu_ALUsrcA !== 2'b01 || cu_ALUsrcB !== 3'b001) begin
        errors++;
        $display("FAIL fetch_ctrl: req=%b irw=%b pcw=%b A=%b B=%b want 1/1/1/01/001", imem_req, cu_IRwrite, cu_PCwrite, cu_ALUsrcA, cu_ALUsrcB);
      end
      tick(); tick();
      @(negedge clk);
      checks++;
      if (state !== S_BR || alu_op !== balu[i] || cu_BrLt !== blt[i] || cu_BrInv !== binv[i] || cu_Branch !== 1 || cu_PCsrc !== 2'b01 || cu_Regwrite !== 0) begin
        errors++;
        $display("FAIL branch f3=%b: state=%0d alu=%b lt=%b inv=%b br=%b pcsrc=%b rw=%b want %0d/%b/%b/%b/1/01/0",
                 bf3[i], state, alu_op, cu_BrLt, cu_BrInv, cu_Branch, cu_PCsrc, cu_Regwrite, S_BR, balu[i], blt[i], binv[i]);
      end
      tick();
      exp_ret++;
    end
    for (int j = 0; j < 2; j++) begin
      opcode = j == 0 ? AUI : LU;
      tick(); tick();
      @(negedge clk);
      checks++;
      if (state !== S_EX_U || cu_ALUsrcA !== (j == 0 ? 2'b11 : 2'b10) || cu_ALUsrcB !== 3'b110 || alu_op !== 4'b0010) begin
        errors++;
        $display("FAIL ex_u op=%b: state=%0d A=%b B=%b alu=%b", opcode, state, cu_ALUsrcA, cu_ALUsrcB, alu_op);
      end
      tick();
      checks++;
      if (state !== S_WB_ALU || cu_Regwrite !== 1 || cu_Mem2Reg !== 2'b00 || cu_PCwrite !== 0) begin
        errors++;
        $display("FAIL wb_u: state=%0d rw=%b m2r=%b pcw=%b want %0d/1/00/0", state, cu_Regwrite, cu_Mem2Reg, cu_PCwrite, S_WB_ALU);
      end
      tick();
      exp_ret++;
    end
    opcode = JL;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (state !== S_JAL || cu_Regwrite !== 1 || cu_Mem2Reg !== 2'b10 || cu_PCwrite !== 1 || cu_PCsrc !== 2'b10) begin
      errors++;
      $display("FAIL jal: state=%0d rw=%b m2r=%b pcw=%b pcsrc=%b want %0d/1/10/1/10", state, cu_Regwrite, cu_Mem2Reg, cu_PCwrite, cu_PCsrc, S_JAL);
    end
    tick();
    exp_ret++;
    opcode = JLR; funct3 = 3'b000;
    tick(); tick();
    checks++;
    if (state !== S_EX_I || alu_op !== 4'b0010 || cu_ALUsrcB !== 3'b010) begin
      errors++;
      $display("FAIL jalr_ex: state=%0d alu=%b B=%b want %0d/0010/010", state, alu_op, cu_ALUsrcB, S_EX_I);
    end
    tick();
    checks++;
    if (state !== S_WB_ALU || cu_Regwrite !== 1 || cu_PCwrite !== 1 || cu_PCsrc !== 2'b11 || cu_Mem2Reg !== 2'b10) begin
      errors++;
      $display("FAIL jalr_wb: state=%0d rw=%b pcw=%b pcsrc=%b m2r=%b want %0d/1/1/11/10", state, cu_Regwrite, cu_PCwrite, cu_PCsrc, cu_Mem2Reg, S_WB_ALU);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== S_FETCH || instret !== 4'(exp_ret)) begin
      errors++;
      $display("FAIL branch_jump_end: state=%0d instret=%0d want %0d/%0d", state, instret, S_FETCH, 4'(exp_ret));
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000; imem_ready = 1'b1;
    tick(); tick();
    checks++;
`ifdef CU_ILLEGAL_TRAP_EN
    if (state !== S_TRAP || trap !== 1 || trap_cause !== 2'b01 || imem_req !== 0 || instret !== 4'(exp_ret)) begin
      errors++;
      $display("FAIL illegal_trap: state=%0d trap=%b cause=%b req=%b instret=%0d want %0d/1/01/0/%0d", state, trap, trap_cause, imem_req, instret, S_TRAP, 4'(exp_ret));
    end
`else
    if (state !== S_FETCH || trap !== 0 || trap_cause !== 2'b00 || instret !== 4'(exp_ret)) begin
      errors++;
      $display("FAIL illegal_nop: state=%0d trap=%b cause=%b instret=%0d want %0d/0/00/%0d", state, trap, trap_cause, instret, S_FETCH, 4'(exp_ret));
    end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = JL; imem_ready = 1'b0;
    repeat (4) tick();
    imem_ready = 1'b1;
    tick();
    checks++;
    if (state !== S_DECODE || trap !== 0) begin errors++; $display("FAIL ready_wins: state=%0d trap=%b want %0d/0", state, trap, S_DECODE); end
    tick(); tick();
    imem_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if (state !== S_FETCH || imem_req !== 1 || trap !== 0) begin
      errors++;
      $display("FAIL imem_wait4: state=%0d req=%b trap=%b want %0d/1/0", state, imem_req, trap, S_FETCH);
    end
    tick();
    checks++;
    if (state !== S_TRAP || trap !== 1 || trap_cause !== 2'b10 || imem_req !== 0) begin
      errors++;
      $display("FAIL imem_timeout: state=%0d trap=%b cause=%b req=%b want %0d/1/10/0", state, trap, trap_cause, imem_req, S_TRAP);
    end
    imem_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (state !== S_TRAP || trap !== 1 || cu_PCwrite !== 0) begin errors++; $display("FAIL trap_hold: state=%0d trap=%b want %0d/1", state, trap, S_TRAP); end
    do_reset();
    opcode = LD; funct3 = 3'b000; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (7) tick();
    checks++;
    if (state !== S_MEM_RD || dmem_req !== 1) begin errors++; $display("FAIL dmem_wait4: state=%0d req=%b want %0d/1", state, dmem_req, S_MEM_RD); end
    tick();
    checks++;
    if (state !== S_TRAP || trap_cause !== 2'b11 || dmem_req !== 0 || instret !== 4'd0) begin
      errors++;
      $display("FAIL dmem_timeout: state=%0d cause=%b req=%b instret=%0d want %0d/11/0/0", state, trap_cause, dmem_req, instret, S_TRAP);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    opcode = JL; imem_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      repeat (3) tick();
      exp_ret++;
      if (i == 15) begin
        checks++;
        if (instret !== 4'hF) begin errors++; $display("FAIL instret_15: got %0d want 15", instret); end
      end
    end
    checks++;
    if (instret !== 4'h0 || state !== S_FETCH) begin errors++; $display("FAIL instret_wrap: got %0d state=%0d want 0/%0d", instret, state, S_FETCH); end
    opcode = SW; funct3 = 3'b010; dmem_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if (state !== S_MEM_WR || dmem_req !== 1 || dmem_we !== 1) begin
      errors++;
      $display("FAIL mem_wr_wait: state=%0d req=%b we=%b want %0d/1/1", state, dmem_req, dmem_we, S_MEM_WR);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== S_FETCH || dmem_req !== 0 || dmem_we !== 0 || instret !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: state=%0d req=%b we=%b instret=%0d want %0d/0/0/0", state, dmem_req, dmem_we, instret, S_FETCH);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cu_mc_hs.md
Name: cu_mc_hs

Overview:
- Parametrised successor to the multicycle RV32I control unit.
- Owns its state register internally; no external State/Next_State loop.
- Adds ready/valid memory handshakes with an optional timeout, full RV32I ALU decode (including AUIPC and sub-word load/store size), a retired-instruction counter, and a trap output.
- Sits between the instruction register/decoder and the multicycle datapath (PC, IR, regfile, ALU, memory port).

Parameters:
- CNT_W, 32: width of the instret counter; wraps modulo 2^CNT_W.
- MEM_TIMEOUT, 0: maximum wait cycles for imem_ready/dmem_ready. 0 disables the timeout.
- TO_W, 8: width of the wait counter. MEM_TIMEOUT must be < 2^TO_W.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- imem_ready  in  1  instruction memory returns data this cycle
- dmem_ready  in  1  data memory completes read/write this cycle
- cu_IRwrite, cu_Regwrite, cu_PCwrite, cu_Branch  out  1 each  datapath enables
- cu_Mem2Reg  out  2  writeback select: 00 ALU, 01 mem, 10 PC+4
- cu_PCsrc  out  2  PC select: 00 ALU, 01 branch target, 10 jal target, 11 ALU&~1
- cu_ALUsrcA  out  2  ALU A select: 00 rs1, 01 PC, 10 zero, 11 oldPC
- cu_ALUsrcB  out  3  ALU B select: 000 rs2, 001 const 4, 010 I-imm, 011 S-imm, 110 U-imm
- alu_op  out  4  ALU operation code
- cu_BrLt  out  1  branch uses the less-than result (1) or the zero flag (0)
- cu_BrInv  out  1  invert branch condition
- imem_req, dmem_req, dmem_we  out  1 each  memory requests
- dmem_size  out  3  funct3 passthrough during MEM_RD/MEM_WR; 0 otherwise
- state  out  5  current state, for debug
- instret  out  CNT_W  retired instruction count
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 illegal, 10 imem timeout, 11 dmem timeout

Behaviour:
- Reset (rst_n low, async):
  - state = FETCH; instret = 0; wait counter = 0; trap = 0; trap_cause = 0.
  - All combinational outputs decode to 0 in FETCH-under-reset, with imem_req forced 0 while rst_n is low.
- Outputs: every output except instret/trap/trap_cause is a combinational function of the registered state, opcode/funct, and ready inputs.
- FETCH:
  - imem_req = 1; ALUsrcA = 01, ALUsrcB = 001, alu_op = ADD.
  - IRwrite and PCwrite assert only in the cycle imem_ready = 1; the state then advances to DECODE.
  - Otherwise the state holds and the wait counter increments.
- DECODE, by opcode:
  - R-type → EX_R
  - OP-IMM and JALR → EX_I
  - BRANCH → BR
  - JAL → JAL
  - LOAD and STORE → MEM_ADDR
  - LUI and AUIPC → EX_U
  - any other opcode → ILLEGAL handling (see Optional Feature)
- Execute states:
  - EX_R: alu_op decoded from {funct7[5], funct3} over all ten R-type ops → WB_ALU.
  - EX_I: ALUsrcB = 010; alu_op decoded from funct3; funct7[5] selects SRAI for funct3 = 101. JALR forces ADD → WB_ALU.
  - EX_U: LUI uses A = 10, B = 110; AUIPC uses A = 11, B = 110; alu_op = ADD → WB_ALU.
  - WB_ALU: Regwrite = 1. For JALR also PCwrite = 1, PCsrc = 11, Mem2Reg = 10 → FETCH.
  - BR: Branch = 1, PCsrc = 01.
    - beq/bne: alu_op = SUB, BrLt = 0.
    - blt/bge: alu_op = SLT, BrLt = 1.
    - bltu/bgeu: alu_op = SLTU, BrLt = 1.
    - BrInv = funct3[0] for every branch.
    - → FETCH.
  - JAL: Regwrite = 1, Mem2Reg = 10, PCwrite = 1, PCsrc = 10 → FETCH.
- Memory states:
  - MEM_ADDR: ALUsrcB = 011 (store) or 010 (load), ADD → MEM_WR or MEM_RD.
  - MEM_RD / MEM_WR: dmem_req = 1; dmem_we = 1 in MEM_WR only; held until dmem_ready.
    - MEM_RD → WB_MEM.
    - MEM_WR → FETCH.
  - WB_MEM: Regwrite = 1, Mem2Reg = 01 → FETCH.
- Wait counter:
  - Clears on every state change.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT while still waiting → TRAP with cause 10 (FETCH) or 11 (MEM_RD/MEM_WR).
  - A ready arriving in the same cycle the counter hits MEM_TIMEOUT wins; no trap is taken.
- instret: increments by 1 on every transition into FETCH from WB_ALU, BR, JAL, MEM_WR or WB_MEM. Wraps modulo 2^CNT_W; no saturation.
- TRAP:
  - All enables 0; no requests; trap = 1.
  - Stays in TRAP until reset.
- Reset mid-wait drops imem_req/dmem_req immediately (async); no partial write is committed by this block.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE → TRAP, trap_cause = 01, instret not incremented.
- Undefined: an illegal opcode → FETCH (treated as a NOP); no trap, instret not incremented.
- Timeout traps exist in both builds.

Decomposition:
- Package cu_mc_pkg holds:
  - state enum (5-bit)
  - opcode constants
  - alu_op codes: AND 0000, OR 0001, ADD 0010, SLTU 0011, SLL 0100, XOR 0101, SUB 0110, SLT 0111, SRL 1000, SRA 1001
  - ALUsrcA/ALUsrcB/PCsrc/Mem2Reg encodings
  - trap cause codes
- One sub-module, cu_alu_dec: a pure combinational map from (class, funct3, funct7[5]) to alu_op. The FSM, wait counter and instret stay in cu_mc_hs.

Test Plan:
- add x3,x1,x2 with imem_ready held high → states FETCH, DECODE, EX_R, WB_ALU, FETCH; alu_op = 0010; Regwrite 1 only in WB_ALU; instret 0 → 1.
- lw with dmem_ready low for 3 cycles → MEM_RD held 4 cycles with dmem_req = 1, dmem_we = 0, dmem_size = 010; then WB_MEM with Mem2Reg = 01.
- MEM_TIMEOUT = 5, imem_ready held low → TRAP entered on the 5th wait cycle; trap = 1, trap_cause = 10; state holds in TRAP until reset.
- bgeu → BR with alu_op = 0011, BrLt = 1, BrInv = 1, Branch = 1; auipc → EX_U with ALUsrcA = 11, ALUsrcB = 110.
- opcode 0000000 → with CU_ILLEGAL_TRAP_EN: TRAP, cause 01; without: back to FETCH, instret unchanged.
- CNT_W = 4 with 16 retired instructions → instret wraps to 0; rst_n low mid-MEM_WR → state FETCH and dmem_req 0 immediately.
